// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e   : loader FSM state encoding
//   LenBytes  : bytes in the little-endian word-count header
//   WordBytes : bytes per 32-bit instruction word
//   CsumBytes : bytes in the trailing checksum
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam int unsigned LenBytes  = 2;
  localparam int unsigned WordBytes = 4;
  localparam int unsigned CsumBytes = 1;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream source plus instruction-memory write port of the loader.
//   in_valid/in_ready/in_data : byte stream, transfer when valid & ready
//   mem_addr/mem_wen/mem_wdata: word write port, captured on the next clk edge
// slave  : the loader side
// master : the stream producer / memory side
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_addr,
    input  mem_wen,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_addr,
    output mem_wen,
    output mem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Loads an instruction memory from a byte stream while holding the core in reset.
// Stream format: 16-bit LE word count N, N words of 4 LE bytes, 1 XOR checksum byte.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle load request (ignored while busy)
//   bus        : byte stream in, memory write port out (imem_loader_if.slave)
//   busy       : load in progress
//   done/error : load finished ok / failed, held until the next start
//   cpu_rst_n  : core reset release, high only after a successful load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ADDR_NUM   = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic           cpu_rst_n
);

  // One extra bit so a count of exactly ADDR_NUM does not wrap to zero.
  localparam int unsigned CntW = ADDR_WIDTH + 1;

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wen_q;

  logic            fire;
  logic            can_start;
  logic            last_word;
  logic [15:0]     len_full;

  assign fire      = bus.in_valid & bus.in_ready;
  assign can_start = start & (state_q inside {StIdle, StDone, StErr});
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);
  // Complete count as it stands when the high byte is being accepted.
  assign len_full  = {bus.in_data, len_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      wdata_q    <= wdata_d;
      // Registered write strobe: high for exactly the cycle spent in StWrite.
      wen_q      <= (state_d == StWrite);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenLo;
      end
      StLenLo: begin
        if (fire) state_d = StLenHi;
      end
      StLenHi: begin
        if (fire) begin
          if (len_full == '0)                  state_d = StCsum;
          else if (32'(len_full) > ADDR_NUM)   state_d = StErr;
          else                                 state_d = StData;
        end
      end
      StData: begin
        if (fire && (byte_cnt_q == 2'(WordBytes - 1))) state_d = StWrite;
      end
      StWrite: begin
        state_d = last_word ? StCsum : StData;
      end
      StCsum: begin
        if (fire) state_d = (bus.in_data == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    wdata_d    = wdata_q;
    if (can_start) begin
      len_d      = '0;
      word_cnt_d = '0;
      byte_cnt_d = '0;
      csum_d     = '0;
    end else if (state_q == StWrite) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end else if (fire) begin
      case (state_q)
        StLenLo: begin
          len_d[7:0] = bus.in_data;
          csum_d     = csum_q ^ bus.in_data;
        end
        StLenHi: begin
          len_d[15:8] = bus.in_data;
          csum_d      = csum_q ^ bus.in_data;
        end
        StData: begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          byte_cnt_d                         = byte_cnt_q + 2'd1;
          csum_d                             = csum_q ^ bus.in_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = state_q inside {StLenLo, StLenHi, StData, StCsum};
    busy          = !(state_q inside {StIdle, StDone, StErr});
    done          = (state_q == StDone);
    error         = (state_q == StErr);
    cpu_rst_n     = (state_q == StDone);
    bus.mem_wen   = wen_q;
    bus.mem_addr  = word_cnt_q[ADDR_WIDTH-1:0];
    bus.mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized byte streams
// compared against a stream-level reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned AN = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, cpu_rst_n;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH(AW),
    .ADDR_NUM  (AN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad = 0;
  logic [7:0]  stim[$];
  logic [63:0] exp_wr[$];
  logic [63:0] got_wr[$];
  logic [31:0] mem_img[AN];
  bit          exp_done, exp_err;
  int          exp_bytes;

  // Memory stand-in: captures every write strobe seen at a rising edge.
  always @(posedge clk) begin
    if (bus.mem_wen) begin
      got_wr.push_back({32'(bus.mem_addr), bus.mem_wdata});
      mem_img[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: interpret the stream as a whole.
  task automatic model_run();
    int         n;
    logic [7:0] cs;
    logic [31:0] word;
    exp_wr.delete();
    n = int'({stim[1], stim[0]});
    if (n > int'(AN)) begin
      exp_err   = 1'b1;
      exp_done  = 1'b0;
      exp_bytes = LenBytes;
      return;
    end
    cs = stim[0] ^ stim[1];
    for (int w = 0; w < n; w++) begin
      word = '0;
      for (int b = 0; b < int'(WordBytes); b++) begin
        word = word | (32'(stim[LenBytes + WordBytes * w + b]) << (8 * b));
        cs   = cs ^ stim[LenBytes + WordBytes * w + b];
      end
      exp_wr.push_back({32'(w), word});
    end
    exp_bytes = LenBytes + WordBytes * n + CsumBytes;
    exp_done  = (stim[exp_bytes - 1] == cs);
    exp_err   = !exp_done;
  endtask

  task automatic gen_stream(input int nwords, input bit bad_csum);
    logic [7:0] cs;
    logic [7:0] b;
    stim.delete();
    stim.push_back(8'(nwords));
    stim.push_back(8'(nwords >> 8));
    cs = stim[0] ^ stim[1];
    for (int i = 0; i < nwords * 4; i++) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back(b);
      cs = cs ^ b;
    end
    stim.push_back(bad_csum ? ~cs : cs);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noisy);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(0, 99) >= gap);
      bus.in_data  = b;
      if (noisy) start = ($urandom_range(0, 3) == 0);
      if (bus.in_valid && bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    check_val("byte_accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
    check_val({tag, ".mem_wen"}, 64'(bus.mem_wen), 64'd0);
    check_val({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check_val({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check_val({tag, ".busy"}, 64'(busy), 64'd0);
    check_val({tag, ".done"}, 64'(done), 64'd0);
    check_val({tag, ".error"}, 64'(error), 64'd0);
    check_val({tag, ".cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
  endtask

  task automatic run_load(input string tag, input int gap, input bit noisy);
    int nmin;
    got_wr.delete();
    model_run();
    pulse_start();
    for (int i = 0; i < exp_bytes; i++) send_byte(stim[i], gap, noisy);
    @(negedge clk);
    check_val({tag, ".busy"}, 64'(busy), 64'd0);
    check_val({tag, ".done"}, 64'(done), 64'(exp_done));
    check_val({tag, ".error"}, 64'(error), 64'(exp_err));
    check_val({tag, ".cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_done));
    check_val({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
    check_val({tag, ".mem_wen"}, 64'(bus.mem_wen), 64'd0);
    check_val({tag, ".nwrites"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    nmin = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < nmin; i++) begin
      if (got_wr[i] !== exp_wr[i]) check_val($sformatf("%s.wr%0d", tag, i), got_wr[i], exp_wr[i]);
      else n_total++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #3;
    check_idle_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two-word directed load; checksum is the XOR of the ten header/data bytes.
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    run_load("dir", 0, 1'b0);
    check_val("dir.mem0", 64'(mem_img[0]), 64'h0000_0013);
    check_val("dir.mem1", 64'(mem_img[1]), 64'h0010_0093);

    // Full-depth load, addresses 0..255.
    gen_stream(256, 1'b0);
    run_load("full", 10, 1'b0);

    // One word too many: rejected after the length header.
    stim = '{8'h01, 8'h01, 8'hAA, 8'hBB};
    run_load("over", 0, 1'b0);

    // Empty image.
    stim = '{8'h00, 8'h00, 8'h00};
    run_load("zero", 0, 1'b0);

    // Bad checksum then a good retry.
    gen_stream(1, 1'b1);
    run_load("badcs", 20, 1'b0);
    gen_stream(1, 1'b0);
    run_load("goodcs", 20, 1'b0);

    // Reset in the middle of a load.
    gen_stream(3, 1'b0);
    got_wr.delete();
    pulse_start();
    for (int i = 0; i < 2 + 5; i++) send_byte(stim[i], 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check_val("midrst.nwrites", 64'(got_wr.size()), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst.nwrites_after", 64'(got_wr.size()), 64'd1);
    check_val("midrst.busy_after", 64'(busy), 64'd0);
    run_load("reload", 20, 1'b0);

    // Gappy stream with spurious start pulses.
    for (int r = 0; r < 3; r++) begin
      gen_stream(3, 1'b0);
      run_load($sformatf("gap%0d", r), 40, 1'b1);
    end

    // Random sizes and checksum faults.
    for (int r = 0; r < 5; r++) begin
      gen_stream(int'($urandom_range(0, 8)), bit'($urandom_range(0, 1)));
      run_load($sformatf("rnd%0d", r), 30, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
